// File: rtl/conv1d_stream_engine_if.sv
// Stream bus for conv1d_stream_engine: job control, sample/coefficient input
// stream, result output stream and status pulses. The master is the side that
// feeds samples and consumes results; the slave is the engine.
`timescale 1ns/1ps
interface conv1d_stream_engine_if #(
    parameter int DW      = 4,
    parameter int K       = 3,
    parameter int MAX_LEN = 16
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int OW = 2 * DW + $clog2(K);

    logic          start;
    logic [LW-1:0] len;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output start, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy, done, err
    );

    modport slave (
        input  start, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy, done, err
    );
endinterface

// File: rtl/conv1d_stream_engine.sv
// Streaming 1-D convolution engine. A job loads K coefficients, then slides a
// K-deep window over len image samples and emits one full dot product per
// complete window. The sum is built combinationally from the stored window
// plus the sample being accepted, so no partial-sum storage is needed.
//
// Handshake: a beat moves on a rising edge exactly when valid and ready are
// both high in the cycle before it; a producer holds valid and its data until
// that edge, and ready never depends combinationally on the matching valid.
`timescale 1ns/1ps
module conv1d_stream_engine #(
    parameter int DW      = 4,
    parameter int K       = 3,
    parameter int MAX_LEN = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    conv1d_stream_engine_if.slave   bus,
    output logic [1:0]              dbgState
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int OW = 2 * DW + $clog2(K);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } stateT;

    stateT         state;
    stateT         stateNext;
    logic [LW-1:0] lenReg;
    logic [LW-1:0] coefCnt;
    logic [LW-1:0] sampleCnt;
    logic [DW-1:0] coef   [K];
    logic [DW-1:0] window [K];
    logic [DW-1:0] tap    [K];
    logic [OW-1:0] sumComb;
    logic [OW-1:0] outDataReg;
    logic          outValidReg;
    logic          outLastReg;
    logic          doneReg;
    logic          errReg;
    logic          inReadyComb;
    logic          inAccept;
    logic          outTake;
    logic          lenOk;
    logic          windowFull;
    logic          lastSample;
    logic          lastCoef;
    logic          flushExit;

    assign lenOk      = (bus.len >= LW'(K)) && (bus.len <= LW'(MAX_LEN));
    assign inAccept   = bus.in_valid & inReadyComb;
    assign outTake    = outValidReg & bus.out_ready;
    assign windowFull = sampleCnt >= LW'(K - 1);
    assign lastSample = sampleCnt == (lenReg - LW'(1));
    assign lastCoef   = coefCnt == LW'(K - 1);
    assign flushExit  = !outValidReg | bus.out_ready;

    // Input readiness: coefficients always accepted, samples only when the result slot frees up.
    always_comb begin
        inReadyComb = 1'b0;
        case (state)
            LOAD:    inReadyComb = 1'b1;
            RUN:     inReadyComb = !outValidReg | bus.out_ready;
            default: inReadyComb = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // Next-state logic for the job sequence IDLE -> LOAD -> RUN -> FLUSH -> IDLE.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (bus.start && lenOk)     stateNext = LOAD;
            LOAD:    if (inAccept && lastCoef)   stateNext = RUN;
            RUN:     if (inAccept && lastSample) stateNext = FLUSH;
            FLUSH:   if (flushExit)              stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Job length latch and the coefficient / sample counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            lenReg    <= '0;
            coefCnt   <= '0;
            sampleCnt <= '0;
        end else begin
            if (state == IDLE && bus.start && lenOk) begin
                lenReg    <= bus.len;
                coefCnt   <= '0;
                sampleCnt <= '0;
            end
            if (state == LOAD && inAccept) coefCnt <= coefCnt + LW'(1);
            if (state == RUN && inAccept)  sampleCnt <= sampleCnt + LW'(1);
        end
    end

    // Coefficient store, written in arrival order coef[0] first.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < K; i++) coef[i] <= '0;
        end else if (state == LOAD && inAccept) begin
            for (int i = 0; i < K; i++) begin
                if (coefCnt == LW'(i)) coef[i] <= bus.in_data;
            end
        end
    end

    // Sample window: oldest at index 0, newest sample shifts in at index K-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < K; i++) window[i] <= '0;
        end else if (state == RUN && inAccept) begin
            for (int i = 0; i < K - 1; i++) window[i] <= window[i + 1];
            window[K - 1] <= bus.in_data;
        end
    end

    // Window as it will be after the incoming sample shifts in.
    always_comb begin
        for (int i = 0; i < K - 1; i++) tap[i] = window[i + 1];
        tap[K - 1] = bus.in_data;
    end

    // Dot product carried at full output width so it can never overflow.
    always_comb begin
        sumComb = '0;
        for (int i = 0; i < K; i++) begin
            sumComb = sumComb + OW'(coef[i]) * OW'(tap[i]);
        end
    end

    // Result register: a load wins over a same-cycle consume, so valid stays high.
    always_ff @(posedge clk) begin
        if (rst) begin
            outDataReg  <= '0;
            outValidReg <= 1'b0;
            outLastReg  <= 1'b0;
        end else if (state == RUN && inAccept && windowFull) begin
            outDataReg  <= sumComb;
            outValidReg <= 1'b1;
            outLastReg  <= lastSample;
        end else if (outTake) begin
            outValidReg <= 1'b0;
        end
    end

    // Status pulses: done as the engine leaves FLUSH, err for a rejected start.
    always_ff @(posedge clk) begin
        if (rst) begin
            doneReg <= 1'b0;
            errReg  <= 1'b0;
        end else begin
            doneReg <= (state == FLUSH) && flushExit;
            errReg  <= (state == IDLE) && bus.start && !lenOk;
        end
    end

    assign bus.in_ready  = inReadyComb;
    assign bus.out_valid = outValidReg;
    assign bus.out_data  = outDataReg;
    assign bus.out_last  = outLastReg;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = doneReg;
    assign bus.err       = errReg;
    assign dbgState      = state;
endmodule

// File: tb/tb_conv1d_stream_engine.sv
// Self-checking bench for conv1d_stream_engine: a default build (K=3, DW=4)
// and a wide build (K=5, DW=8, MAX_LEN=32) share one clock and reset.
`timescale 1ns/1ps
module tb_conv1d_stream_engine;
    localparam int DW = 4, K = 3, MAXL = 16, LW = 5, OW = 10;
    localparam int DW5 = 8, K5 = 5, MAXL5 = 32, LW5 = 6, OW5 = 19;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cycle = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    conv1d_stream_engine_if #(.DW(DW),  .K(K),  .MAX_LEN(MAXL))  bus  ();
    conv1d_stream_engine_if #(.DW(DW5), .K(K5), .MAX_LEN(MAXL5)) bus5 ();
    logic [1:0] dbg, dbg5;

    conv1d_stream_engine #(.DW(DW), .K(K), .MAX_LEN(MAXL)) dut (
        .clk(clk), .rst(rst), .bus(bus), .dbgState(dbg)
    );
    conv1d_stream_engine #(.DW(DW5), .K(K5), .MAX_LEN(MAXL5)) dut5 (
        .clk(clk), .rst(rst), .bus(bus5), .dbgState(dbg5)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int coefM [8];
    int imgM  [40];
    logic [OW-1:0]  expQ [$];
    logic           expLastQ [$];
    logic [OW5-1:0] exp5Q [$];
    logic           exp5LastQ [$];
    logic [OW-1:0]  gotQ [$];
    int             gotCycQ [$];
    logic [OW5-1:0] got5Q [$];
    logic           got5LastQ [$];
    bit             stallArm = 0;

    // y[j] = sum over taps of coef[i] * x[j+i]
    function automatic int modelY(input int k, input int j);
        int s = 0;
        for (int i = 0; i < k; i++) s += coefM[i] * imgM[j + i];
        return s;
    endfunction

    task automatic modelPush(input int l);
        for (int j = 0; j <= l - K; j++) begin
            expQ.push_back(OW'(modelY(K, j)));
            expLastQ.push_back(j == l - K);
        end
    endtask

    task automatic modelPush5(input int l);
        for (int j = 0; j <= l - K5; j++) begin
            exp5Q.push_back(OW5'(modelY(K5, j)));
            exp5LastQ.push_back(j == l - K5);
        end
    endtask

    // ---------------- scoreboards ----------------
    logic [OW-1:0]  expD;
    logic           expL;
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            gotQ.push_back(bus.out_data);
            gotCycQ.push_back(cycle);
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got %0d expected none", bus.out_data);
            end else begin
                expD = expQ.pop_front();
                expL = expLastQ.pop_front();
                check("result_data", 64'(bus.out_data), 64'(expD));
                check("result_last", 64'(bus.out_last), 64'(expL));
            end
        end
    end

    logic [OW5-1:0] exp5D;
    logic           exp5L;
    always @(negedge clk) begin
        if (!rst && bus5.out_valid && bus5.out_ready) begin
            got5Q.push_back(bus5.out_data);
            got5LastQ.push_back(bus5.out_last);
            if (exp5Q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result5: got %0d expected none", bus5.out_data);
            end else begin
                exp5D = exp5Q.pop_front();
                exp5L = exp5LastQ.pop_front();
                check("result5_data", 64'(bus5.out_data), 64'(exp5D));
                check("result5_last", 64'(bus5.out_last), 64'(exp5L));
            end
        end
    end

    // Consumer: ready by default; when armed, stalls 3 cycles on the first result.
    initial begin : stallProc
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (stallArm && bus.out_valid) begin
                stallArm = 0;
                bus.out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("stall_hold_data", 64'(bus.out_data), 64'd14);
                    check("stall_in_ready",  64'(bus.in_ready), 64'd0);
                    check("stall_out_valid", 64'(bus.out_valid), 64'd1);
                    @(posedge clk); #1;
                end
                bus.out_ready = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic sendBeat(input int d);
        logic ok;
        int   n;
        ok = 1'b0;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data = DW'(d);
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = bus.in_ready;
            tick();
            n++;
        end
        check("beat_accepted", 64'(ok), 64'd1);
    endtask

    task automatic sendBeat5(input int d);
        logic ok;
        int   n;
        ok = 1'b0;
        n = 0;
        bus5.in_valid = 1'b1;
        bus5.in_data = DW5'(d);
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = bus5.in_ready;
            tick();
            n++;
        end
        check("beat5_accepted", 64'(ok), 64'd1);
    endtask

    // Full job on the default build; pulseAt >= 0 raises start alongside that sample.
    task automatic runJob(input int l, input int pulseAt);
        bus.start = 1'b1;
        bus.len = LW'(l);
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < K; c++) sendBeat(coefM[c]);
        modelPush(l);
        for (int n = 0; n < l; n++) begin
            if (n == pulseAt) begin
                bus.start = 1'b1;
                bus.len = LW'(4);
            end
            sendBeat(imgM[n]);
            bus.start = 1'b0;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        logic seen;
        int   n;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 100) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
            check({tag, "_state_at_done"}, 64'(dbg), 64'd0);
            if (gotCycQ.size() > 0)
                check({tag, "_done_latency"}, 64'(cycle), 64'(gotCycQ[gotCycQ.size() - 1] + 1));
            tick();
            @(negedge clk);
            check({tag, "_done_pulse_width"}, 64'(bus.done), 64'd0);
            tick();
        end
        check({tag, "_all_results_seen"}, 64'(expQ.size()), 64'd0);
    endtask

    task automatic expectBasic(input string tag);
        check({tag, "_count"}, 64'(gotQ.size()), 64'd3);
        if (gotQ.size() == 3) begin
            check({tag, "_y0"}, 64'(gotQ[0]), 64'd14);
            check({tag, "_y1"}, 64'(gotQ[1]), 64'd20);
            check({tag, "_y2"}, 64'(gotQ[2]), 64'd26);
        end
    endtask

    task automatic setBasic();
        coefM[0] = 1; coefM[1] = 2; coefM[2] = 3;
        for (int i = 0; i < 5; i++) imgM[i] = i + 1;
    endtask

    task automatic illegalStart(input int l);
        bus.start = 1'b1;
        bus.len = LW'(l);
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        check("illegal_err",      64'(bus.err), 64'd1);
        check("illegal_busy",     64'(bus.busy), 64'd0);
        check("illegal_in_ready", 64'(bus.in_ready), 64'd0);
        check("illegal_state",    64'(dbg), 64'd0);
        tick();
        @(negedge clk);
        check("illegal_err_once", 64'(bus.err), 64'd0);
        check("illegal_state2",   64'(dbg), 64'd0);
        tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin : mainSeq
        bus.start = 0; bus.len = '0; bus.in_valid = 0; bus.in_data = '0;
        bus5.start = 0; bus5.len = '0; bus5.in_valid = 0; bus5.in_data = '0;
        bus5.out_ready = 1'b1;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("rst_in_ready",  64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data",  64'(bus.out_data), 64'd0);
        check("rst_out_last",  64'(bus.out_last), 64'd0);
        check("rst_busy",      64'(bus.busy), 64'd0);
        check("rst_done",      64'(bus.done), 64'd0);
        check("rst_err",       64'(bus.err), 64'd0);
        check("rst_state",     64'(dbg), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Basic job: 14, 20, 26 back to back
        setBasic();
        gotQ.delete(); gotCycQ.delete();
        runJob(5, -1);
        waitDone("basic");
        expectBasic("basic");
        if (gotCycQ.size() == 3) begin
            check("basic_throughput01", 64'(gotCycQ[1] - gotCycQ[0]), 64'd1);
            check("basic_throughput12", 64'(gotCycQ[2] - gotCycQ[1]), 64'd1);
        end

        // Max magnitude: 3 * 15 * 15 = 675 twice
        for (int i = 0; i < 3; i++) coefM[i] = 15;
        for (int i = 0; i < 4; i++) imgM[i] = 15;
        gotQ.delete(); gotCycQ.delete();
        runJob(4, -1);
        waitDone("maxmag");
        check("maxmag_count", 64'(gotQ.size()), 64'd2);
        if (gotQ.size() == 2) begin
            check("maxmag_y0", 64'(gotQ[0]), 64'd675);
            check("maxmag_y1", 64'(gotQ[1]), 64'd675);
        end

        // Backpressure on the first result
        setBasic();
        gotQ.delete(); gotCycQ.delete();
        stallArm = 1;
        runJob(5, -1);
        waitDone("stall");
        expectBasic("stall");

        // Illegal lengths
        illegalStart(2);
        illegalStart(17);

        // Reset mid-RUN after the second sample
        setBasic();
        bus.start = 1'b1;
        bus.len = LW'(5);
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < K; c++) sendBeat(coefM[c]);
        sendBeat(imgM[0]);
        sendBeat(imgM[1]);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("abort_in_ready",  64'(bus.in_ready), 64'd0);
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_out_data",  64'(bus.out_data), 64'd0);
        check("abort_out_last",  64'(bus.out_last), 64'd0);
        check("abort_busy",      64'(bus.busy), 64'd0);
        check("abort_done",      64'(bus.done), 64'd0);
        check("abort_err",       64'(bus.err), 64'd0);
        check("abort_state",     64'(dbg), 64'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_done", 64'(bus.done), 64'd0);
            tick();
        end

        // Job after the abort, with a stray start during RUN
        gotQ.delete(); gotCycQ.delete();
        runJob(5, 1);
        waitDone("after_abort");
        expectBasic("after_abort");

        // Wide build: five unit taps over 255 x 6 -> 1275 twice
        for (int i = 0; i < K5; i++) coefM[i] = 1;
        for (int i = 0; i < 6; i++) imgM[i] = 255;
        got5Q.delete(); got5LastQ.delete();
        bus5.start = 1'b1;
        bus5.len = LW5'(6);
        tick();
        bus5.start = 1'b0;
        for (int c = 0; c < K5; c++) sendBeat5(coefM[c]);
        modelPush5(6);
        for (int n = 0; n < 6; n++) sendBeat5(imgM[n]);
        bus5.in_valid = 1'b0;
        begin
            logic seen5;
            seen5 = 1'b0;
            for (int n = 0; n < 50 && !seen5; n++) begin
                @(negedge clk);
                if (bus5.done) seen5 = 1'b1;
                tick();
            end
            check("wide_done_seen", 64'(seen5), 64'd1);
        end
        check("wide_count", 64'(got5Q.size()), 64'd2);
        if (got5Q.size() == 2) begin
            check("wide_y0", 64'(got5Q[0]), 64'd1275);
            check("wide_y1", 64'(got5Q[1]), 64'd1275);
            check("wide_last0", 64'(got5LastQ[0]), 64'd0);
            check("wide_last1", 64'(got5LastQ[1]), 64'd1);
        end
        check("wide_all_results_seen", 64'(exp5Q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Run-time bound
    initial begin : watchdog
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
